// File: rtl/watchdog_obi_regs.sv
// OBI register front-end for the watchdog core: enable/lock, timeout threshold,
// keyed kick, sticky status. Single-cycle response, never stalls.
module watchdog_obi_regs #(
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'd1_000_000,
  parameter logic [31:0] MIN_TIMEOUT     = 32'd16,
  parameter logic [31:0] KICK_KEY        = 32'h5A5A_A5A5,
  parameter logic [31:0] ID_VALUE        = 32'h5744_0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        aid_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        rid_o,
  input  logic        wdt_rst_i,
  output logic        kick_o,
  output logic [31:0] timeout_o
);

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_TIMEOUT = 3'd1;
  localparam logic [2:0] OFF_KICK    = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_ID      = 3'd4;

  logic        en_reg, en_next;
  logic        lock_reg, lock_next;
  logic        fired_reg, fired_next;
  logic        keyerr_reg, keyerr_next;
  logic [31:0] timeout_reg, timeout_next;
  logic        rvalid_reg, err_reg, err_next, rid_reg, kick_reg, kick_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        fired_clr, kick_pulse;
  logic [31:0] timeout_merged;
  logic [2:0]  offset;
  logic        wr, rd;

  assign offset = addr_i[4:2];
  assign wr     = req_i & we_i;
  assign rd     = req_i & ~we_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign timeout_merged[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : timeout_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    en_next      = en_reg;
    lock_next    = lock_reg;
    timeout_next = timeout_reg;
    keyerr_next  = keyerr_reg;
    fired_clr    = 1'b0;
    kick_pulse   = 1'b0;
    err_next     = 1'b0;
    rdata_next   = 32'd0;
    case (offset)
      OFF_CTRL: begin
        if (wr) begin
          if (lock_reg) err_next = 1'b1;
          else if (be_i[0]) begin
            en_next   = wdata_i[0];
            lock_next = wdata_i[1];
          end
        end
        if (rd) rdata_next = {30'd0, lock_reg, en_reg};
      end
      OFF_TIMEOUT: begin
        if (wr) begin
          if (lock_reg) err_next = 1'b1;
          else timeout_next = (timeout_merged < MIN_TIMEOUT) ? MIN_TIMEOUT : timeout_merged;
        end
        if (rd) rdata_next = timeout_reg;
      end
      OFF_KICK: begin
        if (wr) begin
          if (be_i == 4'hF && wdata_i == KICK_KEY) kick_pulse = 1'b1;
          else keyerr_next = 1'b1;
        end
      end
      OFF_STATUS: begin
        if (wr && be_i[0]) begin
          fired_clr = wdata_i[1];
          if (wdata_i[2]) keyerr_next = 1'b0;
        end
        if (rd) rdata_next = {29'd0, keyerr_reg, fired_reg, wdt_rst_i};
      end
      OFF_ID: begin
        if (wr) err_next = 1'b1;
        if (rd) rdata_next = ID_VALUE;
      end
      default: err_next = req_i;
    endcase
    // A firing core while enabled wins over a concurrent software clear
    fired_next = (fired_reg & ~fired_clr) | (wdt_rst_i & en_reg);
    kick_next  = ~en_next | kick_pulse;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_reg      <= 1'b0;
      lock_reg    <= 1'b0;
      fired_reg   <= 1'b0;
      keyerr_reg  <= 1'b0;
      timeout_reg <= DEFAULT_TIMEOUT;
      rvalid_reg  <= 1'b0;
      err_reg     <= 1'b0;
      rid_reg     <= 1'b0;
      rdata_reg   <= 32'd0;
      kick_reg    <= 1'b1;
    end else begin
      en_reg      <= en_next;
      lock_reg    <= lock_next;
      fired_reg   <= fired_next;
      keyerr_reg  <= keyerr_next;
      timeout_reg <= timeout_next;
      rvalid_reg  <= req_i;
      err_reg     <= err_next;
      rid_reg     <= req_i ? aid_i : rid_reg;
      rdata_reg   <= rdata_next;
      kick_reg    <= kick_next;
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_reg;
  assign rdata_o   = rdata_reg;
  assign err_o     = err_reg;
  assign rid_o     = rid_reg;
  assign kick_o    = kick_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_watchdog_obi_regs.sv
// Directed bench for watchdog_obi_regs: register vector table plus kick, status and lock sequences.
module tb_watchdog_obi_regs;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = 32'd0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] wdata_i = 32'd0;
  logic        aid_i = 1'b0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rid_o;
  logic        wdt_rst_i = 1'b0;
  logic        kick_o;
  logic [31:0] timeout_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] DEF_TO = 32'd1_000_000;
  localparam logic [31:0] KEY    = 32'h5A5A_A5A5;

  watchdog_obi_regs dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .rid_o(rid_o), .wdt_rst_i(wdt_rst_i),
    .kick_o(kick_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_timeout;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the falling edge; return after the accepting edge (+1) so the response is visible
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic aid);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata; aid_i = aid;
    @(posedge clk_i);
    #1;
    $display("txn we=%0d addr=%h wdata=%h -> rvalid=%0d rdata=%h err=%0d rid=%0d kick=%0d",
             we, addr, wdata, rvalid_o, rdata_o, err_o, rid_o, kick_o);
  endtask

  task automatic idle();
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic resp(input string name, input logic [31:0] exp_rdata, input logic exp_err,
                      input logic exp_rid);
    check({name, " rvalid"}, {31'd0, rvalid_o}, 32'd1);
    check({name, " rdata"}, rdata_o, exp_rdata);
    check({name, " err"}, {31'd0, err_o}, {31'd0, exp_err});
    check({name, " rid"}, {31'd0, rid_o}, {31'd0, exp_rid});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h5744_0001, 1'b0, DEF_TO};
    vecs[1]  = '{1'b0, 32'h04, 4'hF, 32'h0,         DEF_TO,        1'b0, DEF_TO};
    vecs[2]  = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0,         1'b0, DEF_TO};
    vecs[3]  = '{1'b1, 32'h04, 4'hF, 32'd5,         32'h0,         1'b0, 32'd16};
    vecs[4]  = '{1'b0, 32'h04, 4'hF, 32'h0,         32'd16,        1'b0, 32'd16};
    vecs[5]  = '{1'b1, 32'h04, 4'hF, 32'h1234_5678, 32'h0,         1'b0, 32'h1234_5678};
    vecs[6]  = '{1'b1, 32'h04, 4'h1, 32'd100,       32'h0,         1'b0, 32'h1234_5664};
    vecs[7]  = '{1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h1234_5664};
    vecs[8]  = '{1'b0, 32'h18, 4'hF, 32'h0,         32'h0,         1'b1, 32'h1234_5664};
    vecs[9]  = '{1'b1, 32'h14, 4'hF, 32'h1,         32'h0,         1'b1, 32'h1234_5664};
    vecs[10] = '{1'b0, 32'h08, 4'hF, 32'h0,         32'h0,         1'b0, 32'h1234_5664};
    vecs[11] = '{1'b1, 32'h08, 4'hF, 32'h0,         32'h0,         1'b0, 32'h1234_5664};
    vecs[12] = '{1'b0, 32'h0C, 4'hF, 32'h0,         32'h4,         1'b0, 32'h1234_5664};
    vecs[13] = '{1'b1, 32'h0C, 4'hF, 32'h4,         32'h0,         1'b0, 32'h1234_5664};
    vecs[14] = '{1'b0, 32'h0C, 4'hF, 32'h0,         32'h0,         1'b0, 32'h1234_5664};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("reset rvalid", {31'd0, rvalid_o}, 32'd0);
    check("reset rdata", rdata_o, 32'd0);
    check("reset err", {31'd0, err_o}, 32'd0);
    check("reset kick", {31'd0, kick_o}, 32'd1);
    check("reset timeout", timeout_o, DEF_TO);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i = 1'b1;
    #1;
    check("gnt follows req", {31'd0, gnt_o}, 32'd1);
    req_i = 1'b0;
    #1;
    check("gnt low", {31'd0, gnt_o}, 32'd0);

    // Register table, EN=0 so kick_o stays high
    for (int i = 0; i < 15; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, i[0]);
      resp($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err, i[0]);
      check($sformatf("vec%0d timeout", i), timeout_o, vecs[i].exp_timeout);
      check($sformatf("vec%0d kick", i), {31'd0, kick_o}, 32'd1);
      idle();
      check($sformatf("vec%0d idle rvalid", i), {31'd0, rvalid_o}, 32'd0);
    end

    // Enable: kick_o falls with the response
    txn(1'b1, 32'h00, 4'hF, 32'h1, 1'b0);
    resp("en", 32'h0, 1'b0, 1'b0);
    check("en kick low", {31'd0, kick_o}, 32'd0);
    idle();
    // Good key: single-cycle kick pulse with rvalid
    txn(1'b1, 32'h08, 4'hF, KEY, 1'b1);
    resp("kick", 32'h0, 1'b0, 1'b1);
    check("kick pulse", {31'd0, kick_o}, 32'd1);
    idle();
    check("kick pulse end", {31'd0, kick_o}, 32'd0);
    // Bad key: no pulse, KEYERR
    txn(1'b1, 32'h08, 4'hF, 32'h0, 1'b0);
    resp("badkey", 32'h0, 1'b0, 1'b0);
    check("badkey kick", {31'd0, kick_o}, 32'd0);
    idle();
    txn(1'b0, 32'h0C, 4'hF, 32'h0, 1'b0);
    resp("status keyerr", 32'h4, 1'b0, 1'b0);
    idle();

    // Core fires while enabled
    @(negedge clk_i);
    wdt_rst_i = 1'b1;
    txn(1'b0, 32'h0C, 4'hF, 32'h0, 1'b1);
    resp("status fired", 32'h7, 1'b0, 1'b1);
    txn(1'b1, 32'h0C, 4'hF, 32'h6, 1'b0);
    resp("w1c", 32'h0, 1'b0, 1'b0);
    txn(1'b0, 32'h0C, 4'hF, 32'h0, 1'b1);
    resp("fired sticks", 32'h3, 1'b0, 1'b1);
    idle();
    wdt_rst_i = 1'b0;
    txn(1'b1, 32'h0C, 4'hF, 32'h2, 1'b0);
    idle();
    txn(1'b0, 32'h0C, 4'hF, 32'h0, 1'b0);
    resp("fired cleared", 32'h0, 1'b0, 1'b0);
    idle();

    // Lock
    txn(1'b1, 32'h00, 4'hF, 32'h3, 1'b0);
    resp("lock", 32'h0, 1'b0, 1'b0);
    idle();
    txn(1'b1, 32'h00, 4'hF, 32'h0, 1'b1);
    resp("ctrl locked", 32'h0, 1'b1, 1'b1);
    check("ctrl locked kick", {31'd0, kick_o}, 32'd0);
    idle();
    txn(1'b1, 32'h04, 4'hF, 32'd500, 1'b0);
    resp("timeout locked", 32'h0, 1'b1, 1'b0);
    check("timeout locked value", timeout_o, 32'h1234_5664);
    idle();
    txn(1'b0, 32'h00, 4'hF, 32'h0, 1'b1);
    resp("ctrl readback", 32'h3, 1'b0, 1'b1);

    // Back-to-back: request held high, one response per cycle
    txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
    resp("b2b0", 32'h5744_0001, 1'b0, 1'b0);
    txn(1'b0, 32'h04, 4'hF, 32'h0, 1'b1);
    resp("b2b1", 32'h1234_5664, 1'b0, 1'b1);
    txn(1'b0, 32'h1C, 4'hF, 32'h0, 1'b0);
    resp("b2b2", 32'h0, 1'b1, 1'b0);
    txn(1'b0, 32'h00, 4'hF, 32'h0, 1'b1);
    resp("b2b3", 32'h3, 1'b0, 1'b1);

    // Reset mid-transaction: pending response dropped, lock and timeout restored
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    check("rst mid rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst mid kick", {31'd0, kick_o}, 32'd1);
    check("rst mid timeout", timeout_o, DEF_TO);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post rst rvalid", {31'd0, rvalid_o}, 32'd0);
    txn(1'b0, 32'h00, 4'hF, 32'h0, 1'b0);
    resp("post rst ctrl", 32'h0, 1'b0, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
